sum_accumulator: RTL



---
 rtl/sum_accumulator_pkg.sv | 11 +
 rtl/sum_accumulator_if.sv | 28 ++
 rtl/sum_accumulator_beat_counter.sv | 25 ++
 rtl/sum_accumulator.sv | 61 ++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: FSM state encoding and default widths shared by the accumulator slice.
package sum_accumulator_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: burst control, adder-result input and total-output handshakes.
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_s;
    logic              in_cout;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_total;
    logic              out_overflow;
    logic              busy;
    modport master (
        output start, len, in_valid, in_s, in_cout, out_ready,
        input  in_ready, out_valid, out_total, out_overflow, busy
    );
    modport slave (
        input  start, len, in_valid, in_s, in_cout, out_ready,
        output in_ready, out_valid, out_total, out_overflow, busy
    );
endinterface

// File: rtl/sum_accumulator_beat_counter.sv
// beat_counter: remaining-beat counter; a zero length loads 2^LEN_W.
module beat_counter
    import sum_accumulator_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W:0]   o_cnt,
    output logic             o_zero
);
    logic [LEN_W:0] r_cnt;
    logic [LEN_W:0] w_load_val;
    assign w_load_val = (i_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, i_len};
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= w_load_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums a burst of {cout,sum} adder results and hands out the total with a sticky overflow.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input logic               clk,
    input logic               rst,
    sum_accumulator_if.slave  bus
);
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [LEN_W:0]   w_cnt;
    logic             w_zero;
    logic             w_load;
    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    assign w_load   = (r_state == ST_IDLE) && bus.start;
    assign w_accept = (r_state == ST_ACCUM) && bus.in_valid && !w_zero;
    // one extra bit on the left catches the carry out of the accumulator
    assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'({bus.in_cout, bus.in_s});
    beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_accept),
        .i_len  (bus.len),
        .o_cnt  (w_cnt),
        .o_zero (w_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= ST_ACCUM;
                end
                ST_ACCUM: if (w_accept) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    r_ovf <= r_ovf | w_sum[ACC_W];
                    if (w_cnt == (LEN_W + 1)'(1)) r_state <= ST_DONE;
                end
                ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.in_ready     = (r_state == ST_ACCUM);
    assign bus.out_valid    = (r_state == ST_DONE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.out_total    = r_acc;
    assign bus.out_overflow = r_ovf;
endmodule
